// File: rtl/ins_decoder.sv
// rtl/ins_decoder.sv - instruction decoder/dispatcher for load, save, compute and config instructions.
// Optional opcode/layer-type legality checking is enabled by defining INS_DEC_CHECK_EN.
module ins_decoder #(
  parameter int INST_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  input  logic [INST_W-1:0] ins,
  output logic              ins_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [3:0]        rd_op,
  output logic [5:0]        rd_buf_id,
  output logic [7:0]        rd_size,
  output logic [31:0]       rd_addr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [3:0]        wr_op,
  output logic [5:0]        wr_buf_id,
  output logic [7:0]        wr_size,
  output logic [31:0]       wr_addr,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [61:0]       ex_ins,
  input  logic              rd_busy,
  input  logic              wr_busy,
  input  logic              ex_busy,
  output logic [3:0]        layer_type,
  output logic [3:0]        in_seg,
  output logic [3:0]        out_seg,
  output logic [7:0]        in_img_w,
  output logic [7:0]        out_img_w,
  output logic              cfg_update,
  output logic              err_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CFG_WAIT} state_t;

  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_SAVE = 2'b01;
  localparam logic [1:0] T_COMP = 2'b10;
  localparam logic [1:0] T_CFG  = 2'b11;

  state_t            state_q, state_d;
  logic [INST_W-1:0] ins_q, ins_d;
  logic [3:0]        layer_type_q, in_seg_q, out_seg_q;
  logic [7:0]        in_img_w_q, out_img_w_q;
  logic              cfg_update_q;
  logic              cfg_load;
  logic              err_set;
  logic              legal;
  logic [1:0]        type_q;

  assign type_q = ins_q[63:62];

`ifdef INS_DEC_CHECK_EN
  function automatic logic is_legal(input logic [1:0] t, input logic [3:0] op);
    case (t)
      T_LOAD:  is_legal = op inside {4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      T_SAVE:  is_legal = op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5};
      T_CFG:   is_legal = (op <= 4'h5);
      default: is_legal = 1'b1;
    endcase
  endfunction

  logic err_q;

  assign legal       = is_legal(ins[63:62], ins[61:58]);
  assign err_illegal = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
`else
  assign legal       = 1'b1;
  assign err_illegal = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ins_d    = ins_q;
    cfg_load = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ins_valid) begin
          if (legal) begin
            ins_d   = ins;
            state_d = (ins[63:62] == T_CFG) ? S_CFG_WAIT : S_ISSUE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if ((type_q == T_LOAD && rd_ready) || (type_q == T_SAVE && wr_ready) ||
            (type_q == T_COMP && ex_ready))
          state_d = S_IDLE;
      end
      S_CFG_WAIT: begin
        // Config may only change once every unit has drained.
        if (!(rd_busy || wr_busy || ex_busy)) begin
          cfg_load = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ins_q        <= '0;
      layer_type_q <= '0;
      in_seg_q     <= '0;
      out_seg_q    <= '0;
      in_img_w_q   <= '0;
      out_img_w_q  <= '0;
      cfg_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ins_q        <= ins_d;
      cfg_update_q <= cfg_load;
      if (cfg_load) begin
        layer_type_q <= ins_q[61:58];
        in_seg_q     <= ins_q[55:52];
        out_seg_q    <= ins_q[51:48];
        in_img_w_q   <= ins_q[47:40];
        out_img_w_q  <= ins_q[39:32];
      end
    end
  end

  assign ins_ready = (state_q == S_IDLE);
  assign rd_valid  = (state_q == S_ISSUE) && (type_q == T_LOAD);
  assign wr_valid  = (state_q == S_ISSUE) && (type_q == T_SAVE);
  assign ex_valid  = (state_q == S_ISSUE) && (type_q == T_COMP);

  assign rd_op     = ins_q[61:58];
  assign rd_buf_id = ins_q[57:52];
  assign rd_size   = ins_q[39:32];
  assign rd_addr   = ins_q[31:0];
  assign wr_op     = ins_q[61:58];
  assign wr_buf_id = ins_q[57:52];
  assign wr_size   = ins_q[39:32];
  assign wr_addr   = ins_q[31:0];
  assign ex_ins    = ins_q[61:0];

  assign layer_type = layer_type_q;
  assign in_seg     = in_seg_q;
  assign out_seg    = out_seg_q;
  assign in_img_w   = in_img_w_q;
  assign out_img_w  = out_img_w_q;
  assign cfg_update = cfg_update_q;

endmodule

// File: tb/tb_ins_decoder.sv
// tb/tb_ins_decoder.sv - scoreboard bench for ins_decoder dispatch, config and reset behaviour.
module tb_ins_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic [63:0] ins = '0;
  logic        ins_ready;
  logic        rd_valid, rd_ready = 1'b0;
  logic [3:0]  rd_op;
  logic [5:0]  rd_buf_id;
  logic [7:0]  rd_size;
  logic [31:0] rd_addr;
  logic        wr_valid, wr_ready = 1'b0;
  logic [3:0]  wr_op;
  logic [5:0]  wr_buf_id;
  logic [7:0]  wr_size;
  logic [31:0] wr_addr;
  logic        ex_valid, ex_ready = 1'b0;
  logic [61:0] ex_ins;
  logic        rd_busy = 1'b0, wr_busy = 1'b0, ex_busy = 1'b0;
  logic [3:0]  layer_type, in_seg, out_seg;
  logic [7:0]  in_img_w, out_img_w;
  logic        cfg_update, err_illegal;

  ins_decoder #(.INST_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_op(rd_op), .rd_buf_id(rd_buf_id),
    .rd_size(rd_size), .rd_addr(rd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_op(wr_op), .wr_buf_id(wr_buf_id),
    .wr_size(wr_size), .wr_addr(wr_addr),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ins(ex_ins),
    .rd_busy(rd_busy), .wr_busy(wr_busy), .ex_busy(ex_busy),
    .layer_type(layer_type), .in_seg(in_seg), .out_seg(out_seg),
    .in_img_w(in_img_w), .out_img_w(out_img_w),
    .cfg_update(cfg_update), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cfg_pulses = 0;

`ifdef INS_DEC_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always @(posedge clk) cyc++;

  function automatic logic [63:0] ld(input logic [3:0] op, input logic [5:0] b,
                                     input logic [7:0] sz, input logic [31:0] a);
    return {14'b0, op, b, sz, a};
  endfunction

  function automatic logic [63:0] cfgv(input logic [3:0] lt, input logic [3:0] is,
                                       input logic [3:0] os, input logic [7:0] iw,
                                       input logic [7:0] ow);
    return {36'b0, lt, is, os, iw, ow};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_d(input int kind, input logic [63:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic mon_pop(input int kind, input logic [63:0] act);
    exp_t e;
    hs_cyc.push_back(cyc);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output kind=%0d actual=%0h required=none", kind, act);
    end else begin
      e = q.pop_front();
      chk("out_kind", 64'(kind), 64'(e.kind));
      chk("out_fields", act, e.val);
    end
  endtask

  // Scoreboard monitor: pops on every completed handshake or config update.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("single_valid", {63'b0, ($countones({rd_valid, wr_valid, ex_valid}) <= 1)}, 64'd1);
      if (rd_valid && rd_ready) mon_pop(0, {14'b0, rd_op, rd_buf_id, rd_size, rd_addr});
      if (wr_valid && wr_ready) mon_pop(1, {14'b0, wr_op, wr_buf_id, wr_size, wr_addr});
      if (ex_valid && ex_ready) mon_pop(2, {2'b0, ex_ins});
      if (cfg_update) begin
        cfg_pulses++;
        mon_pop(3, {36'b0, layer_type, in_seg, out_seg, in_img_w, out_img_w});
      end
    end
  end

  task automatic send(input logic [63:0] w);
    int n = 0;
    ins       = w;
    ins_valid = 1'b1;
    @(negedge clk);
    while (!ins_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ins_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ins_ready", ins_ready, 1);
    chk("rst_valids", {rd_valid, wr_valid, ex_valid}, 0);
    chk("rst_cfg_update", cfg_update, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_cfg_regs", {layer_type, in_seg, out_seg, in_img_w, out_img_w}, 0);
    chk("rst_fields", {rd_addr, wr_size, ex_ins[31:0]}, 0);
    rst_n = 1'b1;
    step();

    // Load with immediate ready
    rd_ready = 1'b1;
    expect_d(0, ld(4'h0, 6'd1, 8'h10, 32'h1000));
    send(64'h0014_0A10_0000_1000);
    @(negedge clk);
    chk("load_valid", rd_valid, 1);
    chk("load_ins_ready_low", ins_ready, 0);
    chk("load_fields", {rd_buf_id, rd_size, rd_addr}, {6'd1, 8'h10, 32'h1000});
    @(negedge clk);
    chk("load_valid_drop", rd_valid, 0);
    chk("load_ins_ready_back", ins_ready, 1);
    step();

    // Save with backpressure
    wr_ready = 1'b0;
    expect_d(1, ld(4'h2, 6'd5, 8'h20, 32'hDEAD_BEEF));
    send(64'h4850_0020_DEAD_BEEF);
    repeat (5) begin
      @(negedge clk);
      chk("save_hold_valid", wr_valid, 1);
      chk("save_hold_fields", {14'b0, wr_op, wr_buf_id, wr_size, wr_addr},
          ld(4'h2, 6'd5, 8'h20, 32'hDEAD_BEEF));
      chk("save_hold_no_accept", ins_ready, 0);
      step();
    end
    wr_ready = 1'b1;
    @(negedge clk);
    chk("save_valid_6th", wr_valid, 1);
    step();
    wr_ready = 1'b0;
    @(negedge clk);
    chk("save_valid_drop", wr_valid, 0);
    chk("save_ins_ready_back", ins_ready, 1);
    step();

    // Config held by ex_busy
    ex_busy    = 1'b1;
    cfg_pulses = 0;
    expect_d(3, cfgv(4'd2, 4'd3, 4'd4, 8'd28, 8'd14));
    send(64'hC834_1C0E_0000_0000);
    repeat (8) begin
      @(negedge clk);
      chk("cfg_wait_no_update", cfg_update, 0);
      chk("cfg_wait_ins_ready", ins_ready, 0);
      step();
    end
    ex_busy = 1'b0;
    @(negedge clk);
    chk("cfg_not_yet", cfg_update, 0);
    step();
    @(negedge clk);
    chk("cfg_pulse", cfg_update, 1);
    chk("cfg_regs", {36'b0, layer_type, in_seg, out_seg, in_img_w, out_img_w},
        cfgv(4'd2, 4'd3, 4'd4, 8'd28, 8'd14));
    step();
    @(negedge clk);
    chk("cfg_pulse_end", cfg_update, 0);
    chk("cfg_idle", ins_ready, 1);
    chk("cfg_pulse_count", 64'(cfg_pulses), 64'd1);
    step();

    // Load opcode 0011: illegal when checking, dispatched otherwise
    rd_ready = 1'b1;
`ifndef INS_DEC_CHECK_EN
    expect_d(0, ld(4'h3, 6'd2, 8'h04, 32'h40));
`endif
    send(64'h0C20_0004_0000_0040);
    @(negedge clk);
    chk("op3_rd_valid", rd_valid, !EXP_ERR);
    chk("op3_err", err_illegal, EXP_ERR);
    chk("op3_ins_ready", ins_ready, EXP_ERR);
    step();
    expect_d(0, ld(4'h4, 6'd3, 8'h08, 32'h2000));
    send(64'h1030_0008_0000_2000);
    @(negedge clk);
    chk("after_illegal_valid", rd_valid, 1);
    chk("err_sticky", err_illegal, EXP_ERR);
    step();

    // Layer type 6: dropped when checking, applied otherwise
`ifndef INS_DEC_CHECK_EN
    expect_d(3, cfgv(4'd6, 4'd0, 4'd0, 8'd0, 8'd0));
`endif
    send(64'hD800_0000_0000_0000);
    repeat (3) step();
    chk("lt6_ins_ready", ins_ready, 1);
    chk("lt6_err", err_illegal, EXP_ERR);

    // Back-to-back load, compute, save
    rd_ready = 1'b1;
    wr_ready = 1'b1;
    ex_ready = 1'b1;
    hs_cyc.delete();
    expect_d(0, ld(4'h5, 6'd7, 8'h33, 32'h1111_2222));
    expect_d(2, 64'h0123_4567_89AB_CDEF);
    expect_d(1, ld(4'h5, 6'd9, 8'h7F, 32'hCAFE_0000));
    send(64'h1470_0033_1111_2222);
    send(64'h8123_4567_89AB_CDEF);
    send(64'h5490_007F_CAFE_0000);
    repeat (3) step();
    chk("b2b_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);
      chk("b2b_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);
    end

    // Reset during ISSUE
    rd_ready = 1'b0;
    send(64'h0000_0000_0000_0ABC);
    @(negedge clk);
    chk("pre_reset_valid", rd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_valid", rd_valid, 0);
    chk("reset_async_ready", ins_ready, 1);
    chk("reset_err_clear", err_illegal, 0);
    chk("reset_cfg_clear", {layer_type, in_img_w}, 0);
    step();
    rst_n    = 1'b1;
    rd_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_dispatch", rd_valid, 0);
      chk("post_reset_ready", ins_ready, 1);
    end

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_decoder.md
# ins_decoder

Instruction front end of the training accelerator. Accepts the 64-bit instruction stream from the host FIFO, decodes the type field, and dispatches load, save and compute instructions to their execution units over valid/ready handshakes. Configuration instructions are held until all units drain, then update the layer configuration registers. Sits between the instruction FIFO and the load, save and compute units.

## Interface
- INST_W, 64, instruction width; fields below are fixed for 64.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ins_valid  in  1  instruction available
- ins  in  INST_W  instruction word
- ins_ready  out  1  decoder accepts instruction
- rd_valid / rd_ready  out / in  1 / 1  load dispatch handshake
- rd_op  out  4  ins[61:58]
- rd_buf_id  out  6  ins[57:52]
- rd_size  out  8  ins[39:32]
- rd_addr  out  32  ins[31:0]
- wr_valid / wr_ready  out / in  1 / 1  save dispatch handshake
- wr_op, wr_buf_id, wr_size, wr_addr  out  4, 6, 8, 32  same field positions as load
- ex_valid / ex_ready  out / in  1 / 1  compute dispatch handshake
- ex_ins  out  62  ins[61:0]
- rd_busy, wr_busy, ex_busy  in  1 each  unit still executing
- layer_type  out  4  cfg ins[61:58]
- in_seg, out_seg  out  4 each  ins[55:52], ins[51:48]
- in_img_w, out_img_w  out  8 each  ins[47:40], ins[39:32]
- cfg_update  out  1  one-cycle pulse when config registers change
- err_illegal  out  1  sticky illegal-instruction flag

## Operation
- Type ins[63:62]: 00 load, 01 save, 10 compute, 11 config.
- FSM states:
  - IDLE: ins_ready=1. On ins_valid, latch ins and go to ISSUE (types 00/01/10) or CFG_WAIT (11). Illegal instructions are dropped, set err_illegal, and stay in IDLE.
  - ISSUE: assert exactly one of rd_valid/wr_valid/ex_valid with latched fields. On matching ready, return to IDLE.
  - CFG_WAIT: wait for rd_busy=wr_busy=ex_busy=0 in the same cycle. Then load the config registers, pulse cfg_update and go to IDLE.
- Legal load ops: 0000, 0010, 0100, 0101, 0110, 0111, 1000.
- Legal save ops: 0000, 0010, 0011, 0100, 0101.
- Legal layer types: 0000–0101.
- Compute instructions are never checked.
- Only one dispatch valid is ever high at a time. Instructions issue strictly in order.
- err_illegal is cleared only by reset.

## Timing
- Reset values:
  - ins_ready=1 (state IDLE).
  - All *_valid=0, cfg_update=0, err_illegal=0.
  - All config registers and dispatch fields =0.
- Dispatch valid rises the cycle after acceptance. Minimum of 2 cycles per dispatched instruction.
- Dispatch valid and fields stay stable until the handshake. Valid drops the cycle after ready is sampled high.
- ins_ready is purely a function of state. It has no combinational path from any *_ready or busy input.
- Config registers change and cfg_update pulses the cycle after the first all-idle sample. The earliest such sample is the cycle after acceptance.
- Illegal instruction: err_illegal is set the cycle after acceptance, no dispatch occurs, and ins_ready stays 1.
- Busy inputs are not examined for load/save/compute dispatch; downstream ready provides backpressure.
- Reset asserted mid-operation: any pending instruction is discarded and all outputs return to reset values asynchronously.

## Configuration
- INS_DEC_CHECK_EN defined:
  - Load/save opcodes and layer types are checked as in Operation.
  - Illegal instructions are dropped and set err_illegal.
- Not defined:
  - No opcode or layer-type checking.
  - Every load/save instruction is dispatched.
  - Every config instruction is applied.
  - err_illegal is tied to 0.

## Test plan
- Load 0x0014_0A10_0000_1000 (op 0000, buf 1, size 0x10, addr 0x1000), rd_ready=1 -> rd_valid one cycle later with rd_buf_id=1, rd_size=0x10, rd_addr=0x1000; ins_ready low for exactly one cycle.
- Save op 0010 with wr_ready held low 5 cycles -> wr_valid and fields stable for 6 cycles; next instruction not accepted until the handshake.
- Config layer_type 0010, in_seg 3, out_seg 4, widths 28/14 while ex_busy high 10 cycles -> cfg_update pulses exactly once, the cycle after ex_busy falls; registers read 2/3/4/28/14.
- Load opcode 0011 with INS_DEC_CHECK_EN -> no rd_valid, err_illegal=1 persists, next legal instruction dispatches normally. Without the macro -> dispatched with rd_op=0011.
- Back-to-back load, compute, save with all ready=1 -> dispatched in order at 2-cycle spacing, never two valids high together.
- rst_n pulsed low while in ISSUE -> rd_valid=0 immediately, ins_ready=1 after release, the pending instruction is never dispatched.
